morse_tx: RTL and testbench
===========================

Name: morse_tx

Overview:
Morse transmitter: the other end of the button-driven Morse decoder link. It accepts one character at a time (a symbol pattern plus length) over a valid/ready handshake and drives a single key line (LED/buzzer/loopback into the decoder) with standard Morse timing:
- dot = 1 unit, dash = 3 units
- intra-character gap = 1 unit
- inter-character gap = 3 units, word gap = 7 units

It sits between a character source (UART/ROM sequencer) and the key output pin.

Parameters:
UNIT_CYCLES, 12_000_000, clk cycles per Morse time unit (120 ms at 100 MHz); legal range 2 or more.
MAX_SYMBOLS, 5, maximum dots/dashes per character; fixes char_code width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
char_valid  input  1  source presents a character
char_ready  output  1  transmitter can accept; registered
char_code  input  MAX_SYMBOLS  symbol pattern; bit i = symbol i, 1 = dash, 0 = dot; bit 0 is sent first (same encoding the decoder stores)
char_len  input  3  number of symbols, 0..MAX_SYMBOLS
word_end  input  1  follow this character with a word gap instead of a character gap
key_out  output  1  Morse key line; 1 = tone/on; registered
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (sync): state=IDLE, key_out=0, char_ready=1, busy=0, all counters=0. Reset mid-character aborts it; key_out is 0 from the edge after reset is sampled.
- Handshake: transfer occurs on a rising edge with char_valid && char_ready.
  - char_ready is 1 only in IDLE and drops the cycle after transfer.
  - char_code, char_len and word_end are captured at transfer. Inputs are don't-care otherwise.
  - char_valid may rise or fall at any time; there is no requirement to hold it.
- States (enum in package): IDLE, SYM_ON, SYM_GAP, CHAR_GAP.
- IDLE:
  - Transfer with char_len >= 1 goes to SYM_ON with index=0.
  - Transfer with char_len = 0 (space) goes directly to CHAR_GAP with a 7-unit target; key stays 0.
  - char_len > MAX_SYMBOLS is clamped to MAX_SYMBOLS.
- SYM_ON:
  - key_out=1 for 1 unit if code[index]=0, or 3 units if code[index]=1.
  - key_out rises the cycle after transfer: latency 1 clk.
  - On expiry: if index = len-1, go to CHAR_GAP with target 7 units if word_end else 3. Otherwise go to SYM_GAP.
- SYM_GAP: key_out=0 for 1 unit, then index++ and return to SYM_ON.
- CHAR_GAP: key_out=0 for the target units, then go to IDLE (char_ready=1 next cycle).
- Timing is exact to the clock:
  - an N-unit interval = N*UNIT_CYCLES cycles of constant key_out;
  - the IDLE/accept cycle adds exactly 1 low cycle between back-to-back characters.
- Counters:
  - Cycle counter width $clog2(UNIT_CYCLES), restarted on every state entry, emits a 1-cycle unit tick at UNIT_CYCLES-1 and wraps to 0.
  - Unit counter is 3 bits (max 7), cleared on state entry.
  - Interval expiry = unit tick while unit_count = target-1.
- Simultaneous events: char_valid asserted while busy is ignored, with no queuing. The source holds it until char_ready.
- No ERROR state. The illegal state encoding returns to IDLE on the next edge with key_out=0.

Decomposition:
- Package morse_pkg (shared with the decoder):
  - tx state enum;
  - MAX_SYMBOLS;
  - DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7.
- Sub-module morse_unit_timer:
  - parameter UNIT_CYCLES;
  - inputs clk, reset, restart;
  - outputs unit_tick and unit_count[2:0].
- The FSM, index and capture registers live in morse_tx.

Test Plan:
1. UNIT_CYCLES=4, 'E' (len=1, code=00000) -> key_out high exactly 4 cycles starting 1 clk after transfer, then low 12, then char_ready=1; busy high for 16 cycles.
2. 'A' (len=2, code=00010) -> key high 4, low 4, high 12, low 12, char_ready returns.
3. Back-to-back 'T' (len=1, code=1) then 'T' with char_valid held -> high 12, low 12+1, high 12; the second transfer occurs on the first IDLE cycle.
4. 'S' with word_end=1, then a len=0 space -> high/low 4/4/4/4/4, low 28; the space gives 28 more low cycles with key never high.
5. len=7 (clamped), code=11111 -> exactly 5 dashes of 12 cycles each; char_valid pulsed while busy is ignored and char_ready stays 0.
6. Reset asserted 6 cycles into a dash -> key_out=0, char_ready=1, busy=0 the edge after; a new 'E' afterwards times exactly as in scenario 1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: transmitter state encoding, symbol limit and
// interval lengths in Morse time units.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYM_ON,
        SYM_GAP,
        CHAR_GAP
    } tx_state_e;

    localparam int MAX_SYMBOLS = 5;

    localparam logic [2:0] DOT_UNITS      = 3'd1;
    localparam logic [2:0] DASH_UNITS     = 3'd3;
    localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

    function automatic logic [2:0] sym_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_tx_if.sv
// Character handshake between a character source and the Morse transmitter.
interface morse_tx_if #(
    parameter int MAX_SYMBOLS = morse_pkg::MAX_SYMBOLS
);
    logic                   char_valid;
    logic                   char_ready;
    logic [MAX_SYMBOLS-1:0] char_code;
    logic [2:0]             char_len;
    logic                   word_end;

    modport master (
        output char_valid, char_code, char_len, word_end,
        input  char_ready
    );

    modport slave (
        input  char_valid, char_code, char_len, word_end,
        output char_ready
    );
endinterface

// File: rtl/morse_unit_timer.sv
// Morse unit timebase: cycle counter producing a one-cycle tick per unit and
// a count of whole units elapsed since the last restart.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 12_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    output logic       unit_tick,
    output logic [2:0] unit_count
);
    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    units_q, units_d;

    assign unit_tick  = (cyc_q == LAST);
    assign unit_count = units_q;

    always_comb begin
        cyc_d   = cyc_q + CW'(1);
        units_d = units_q;
        if (restart) begin
            cyc_d   = '0;
            units_d = '0;
        end else if (unit_tick) begin
            cyc_d   = '0;
            units_d = units_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q   <= '0;
            units_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            units_q <= units_d;
        end
    end
endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: accepts one character per handshake and keys it out
// with standard dot/dash/gap timing.
module morse_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_000_000,
    parameter int MAX_SYMBOLS = morse_pkg::MAX_SYMBOLS
) (
    input  logic       clk,
    input  logic       reset,
    morse_tx_if.slave  ch,
    output logic       key_out,
    output logic       busy
);
    localparam logic [2:0] MAX_LEN = 3'(MAX_SYMBOLS);

    tx_state_e              state_q, state_d;
    logic [MAX_SYMBOLS-1:0] code_q, code_d;
    logic [2:0]             len_q, len_d;
    logic                   word_q, word_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             tgt_q, tgt_d;
    logic                   key_q, key_d;
    logic                   ready_q, ready_d;

    logic                   restart, unit_tick, expiry;
    logic [2:0]             unit_count, len_in, idx_nxt;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .unit_tick  (unit_tick),
        .unit_count (unit_count)
    );

    assign expiry     = unit_tick && (unit_count == tgt_q - 3'd1);
    assign len_in     = (ch.char_len > MAX_LEN) ? MAX_LEN : ch.char_len;
    assign idx_nxt    = idx_q + 3'd1;
    // Timer is held cleared while idle so every interval starts from zero.
    assign restart    = (state_d != state_q) || (state_q == IDLE);
    assign key_out    = key_q;
    assign ch.char_ready = ready_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        word_d  = word_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (ch.char_valid && ready_q) begin
                    code_d = ch.char_code;
                    len_d  = len_in;
                    word_d = ch.word_end;
                    idx_d  = '0;
                    if (len_in == 3'd0) begin
                        state_d = CHAR_GAP;
                        tgt_d   = WORD_GAP_UNITS;
                    end else begin
                        state_d = SYM_ON;
                        tgt_d   = sym_units(ch.char_code[0]);
                    end
                end
            end
            SYM_ON: begin
                if (expiry) begin
                    if (idx_q == len_q - 3'd1) begin
                        state_d = CHAR_GAP;
                        tgt_d   = word_q ? WORD_GAP_UNITS : CHAR_GAP_UNITS;
                    end else begin
                        state_d = SYM_GAP;
                        tgt_d   = SYM_GAP_UNITS;
                    end
                end
            end
            SYM_GAP: begin
                if (expiry) begin
                    state_d = SYM_ON;
                    idx_d   = idx_nxt;
                    tgt_d   = sym_units(code_q[idx_nxt]);
                end
            end
            CHAR_GAP: begin
                if (expiry) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        key_d   = (state_d == SYM_ON);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            len_q   <= '0;
            word_q  <= 1'b0;
            idx_q   <= '0;
            tgt_q   <= '0;
            key_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            key_q   <= key_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx at UNIT_CYCLES=4: key_out is recorded as
// run lengths (+high / -low) and compared against hand-computed tables.
module tb_morse_tx;
    localparam int UC = 4;
    localparam int NR = 12;

    typedef struct {
        string      name;
        logic [4:0] code;
        logic [2:0] len;
        logic       word;
        int         pulse_at;
        int         n_runs;
        int         runs[NR];
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_out, busy;

    morse_tx_if #(.MAX_SYMBOLS(5)) ch ();

    morse_tx #(.UNIT_CYCLES(UC), .MAX_SYMBOLS(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .ch      (ch),
        .key_out (key_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   runs[$];
    int   busy_n;
    vec_t vecs[7];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add_sample(input logic k);
        int last;
        last = runs.size() - 1;
        if (runs.size() == 0 || (k && runs[last] < 0) || (!k && runs[last] > 0))
            runs.push_back(k ? 1 : -1);
        else
            runs[last] = runs[last] + (k ? 1 : -1);
    endtask

    task automatic check_runs(input string nm, input int n, input int e[NR]);
        check({nm, "_nruns"}, runs.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < runs.size()) check($sformatf("%s_run%0d", nm, i), runs[i], e[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!ch.char_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check({nm, "_ready_timeout"}, 0, 1);
    endtask

    task automatic send_measure(input vec_t v);
        int cyc;
        int exp_busy;
        wait_ready(v.name);
        ch.char_code  = v.code;
        ch.char_len   = v.len;
        ch.word_end   = v.word;
        ch.char_valid = 1'b1;
        tick();
        ch.char_valid = 1'b0;
        check({v.name, "_ready_drop"}, int'(ch.char_ready), 0);
        runs.delete();
        busy_n = 0;
        cyc = 0;
        while (!ch.char_ready && cyc < 300) begin
            add_sample(key_out);
            if (busy) busy_n++;
            if (v.pulse_at != 0 && cyc == v.pulse_at) begin
                ch.char_valid = 1'b1;
                ch.char_code  = 5'b00000;
                ch.char_len   = 3'd1;
            end
            if (v.pulse_at != 0 && cyc == v.pulse_at + 3) ch.char_valid = 1'b0;
            if (ch.char_valid) check({v.name, "_ready_hold"}, int'(ch.char_ready), 0);
            tick();
            cyc++;
        end
        if (cyc >= 300) check({v.name, "_done_timeout"}, 0, 1);
        check_runs(v.name, v.n_runs, v.runs);
        exp_busy = 0;
        for (int i = 0; i < v.n_runs; i++)
            exp_busy += (v.runs[i] < 0) ? -v.runs[i] : v.runs[i];
        check({v.name, "_busy_cycles"}, busy_n, exp_busy);
    endtask

    initial begin
        int e[NR];
        int cyc, n_xfer;
        logic prev_ready;

        vecs[0] = '{"E", 5'b00000, 3'd1, 1'b0, 0, 2,
                    '{4, -12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[1] = '{"A", 5'b00010, 3'd2, 1'b0, 0, 4,
                    '{4, -4, 12, -12, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{"S_word", 5'b00000, 3'd3, 1'b1, 0, 6,
                    '{4, -4, 4, -4, 4, -28, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{"space", 5'b10101, 3'd0, 1'b0, 0, 1,
                    '{-28, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{"clamp7", 5'b11111, 3'd7, 1'b0, 20, 10,
                    '{12, -4, 12, -4, 12, -4, 12, -4, 12, -12, 0, 0}};
        vecs[5] = '{"mix5", 5'b01101, 3'd5, 1'b0, 0, 10,
                    '{12, -4, 4, -4, 12, -4, 12, -4, 4, -12, 0, 0}};
        vecs[6] = '{"R_hibits", 5'b11010, 3'd3, 1'b0, 0, 6,
                    '{4, -4, 12, -4, 4, -12, 0, 0, 0, 0, 0, 0}};

        ch.char_valid = 1'b0;
        ch.char_code  = '0;
        ch.char_len   = '0;
        ch.word_end   = 1'b0;
        repeat (3) tick();
        check("reset_key", int'(key_out), 0);
        check("reset_ready", int'(ch.char_ready), 1);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) send_measure(vecs[i]);

        // Back-to-back 'T' with char_valid held: second transfer on first IDLE cycle.
        wait_ready("tt");
        ch.char_code  = 5'b00001;
        ch.char_len   = 3'd1;
        ch.word_end   = 1'b0;
        ch.char_valid = 1'b1;
        runs.delete();
        prev_ready = ch.char_ready;
        n_xfer = 0;
        cyc = 0;
        while (cyc < 200) begin
            tick();
            cyc++;
            if (prev_ready && ch.char_valid) n_xfer++;
            if (n_xfer == 2) ch.char_valid = 1'b0;
            if (n_xfer == 2 && ch.char_ready) break;
            add_sample(key_out);
            prev_ready = ch.char_ready;
        end
        if (cyc >= 200) check("tt_timeout", 0, 1);
        check("tt_xfers", n_xfer, 2);
        e = '{12, -13, 12, -12, 0, 0, 0, 0, 0, 0, 0, 0};
        check_runs("tt", 4, e);

        // Reset six cycles into a dash, then a clean 'E'.
        wait_ready("rst");
        ch.char_code  = 5'b00001;
        ch.char_len   = 3'd1;
        ch.char_valid = 1'b1;
        tick();
        ch.char_valid = 1'b0;
        repeat (5) tick();
        check("rst_key_before", int'(key_out), 1);
        reset = 1'b1;
        tick();
        check("rst_key", int'(key_out), 0);
        check("rst_ready", int'(ch.char_ready), 1);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();
        send_measure(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
